// File: rtl/booth_mul_seq.sv
// booth_mul_seq: multi-cycle signed radix-4 Booth multiplier.
// Operand A (multiplicand) comes from Y and operand B (multiplier) from the bus.
// The 2*WIDTH product is presented on product/zhi/zlo with a start/done handshake.
// Timing: start accepted at edge 0, iterations on edges 1..WIDTH/2,
// and product registered with done raised on edge WIDTH/2+1.

module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     zhi,
    output logic [WIDTH-1:0]     zlo
);

    // Accumulator carries two guard bits so that +/-2M never overflows.
    localparam int ACC_W = WIDTH + 2;
    localparam int ITERS = WIDTH / 2;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [ACC_W-1:0]     mcand;
    logic signed [ACC_W-1:0]     acc;
    logic        [WIDTH:0]       q;
    logic        [CNT_W-1:0]     count;

    logic signed [ACC_W-1:0]     acc_sum;
    logic signed [ACC_W+WIDTH:0] shift_in;
    logic signed [ACC_W+WIDTH:0] shifted;
    logic signed [ACC_W-1:0]     acc_next;
    logic        [WIDTH:0]       q_next;

    logic accept;
    logic iterate;
    logic finish;

    // Radix-4 Booth recoding of a 3-bit window into a signed partial product.
    function automatic logic signed [ACC_W-1:0] booth_term(
        input logic        [2:0]       bits,
        input logic signed [ACC_W-1:0] m
    );
        logic signed [ACC_W-1:0] term;
        case (bits)
            3'b001, 3'b010: term = m;
            3'b011:         term = m <<< 1;
            3'b100:         term = -(m <<< 1);
            3'b101, 3'b110: term = -m;
            default:        term = '0;
        endcase
        booth_term = term;
    endfunction

    assign accept  = (state == IDLE) && start;
    assign iterate = (state == RUN) && (count != LAST);
    assign finish  = (state == RUN) && (count == LAST);

    // One Booth step: add the recoded term, then arithmetic shift {acc, q} by two.
    always_comb begin
        acc_sum  = acc + booth_term(q[2:0], mcand);
        shift_in = {acc_sum, q};
        shifted  = shift_in >>> 2;
        acc_next = shifted[ACC_W+WIDTH:WIDTH+1];
        q_next   = shifted[WIDTH:0];
    end

    // State register; clr drops everything back to IDLE immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Iteration counter: cleared on accept, counts Booth steps during RUN.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
        end else if (iterate) begin
            count <= count + CNT_W'(1);
        end
    end

    // Working datapath: operand capture on accept, shift-add during RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
            acc   <= '0;
            q     <= {multiplier, 1'b0};
        end else if (iterate) begin
            acc <= acc_next;
            q   <= q_next;
        end
    end

    // Result register: loaded on the edge entering DONE, held until the next result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            product <= '0;
        end else if (finish) begin
            product <= {acc[WIDTH-1:0], q[WIDTH:1]};
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign zhi  = product[2*WIDTH-1:WIDTH];
    assign zlo  = product[WIDTH-1:0];

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: randomized and directed bench for booth_mul_seq with a
// cycle-level behavioural model of the handshake and plain signed arithmetic.

module tb_booth_mul_seq;

    localparam int W   = 32;
    localparam int LAT = W / 2 + 1;

    logic            clk = 1'b0;
    logic            clr = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    multiplicand = '0;
    logic [W-1:0]    multiplier = '0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;
    logic [W-1:0]    zhi;
    logic [W-1:0]    zlo;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    bit mon_en   = 1'b0;

    // Behavioural model state
    bit             m_active  = 1'b0;
    int             m_cnt     = 0;
    logic [2*W-1:0] m_prod    = '0;
    logic [2*W-1:0] m_pending = '0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .zhi          (zhi),
        .zlo          (zlo)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        ref_mul = sa * sb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: accepts start only when idle, result appears LAT edges later, busy one more edge.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_prod   = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active  = 1'b1;
                m_cnt     = 0;
                m_pending = ref_mul(multiplicand, multiplier);
            end
        end else begin
            m_cnt++;
            if (m_cnt == LAT) m_prod = m_pending;
            if (m_cnt == LAT + 1) m_active = 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mon_en) begin
            check("busy", busy, m_active);
            check("done", done, (m_active && m_cnt == LAT));
            check("product", product, m_prod);
            check("zhi", zhi, m_prod[2*W-1:W]);
            check("zlo", zlo, m_prod[W-1:0]);
        end
    end

    // Launch one operation from IDLE, optionally poke start at edge inject_at, wait for done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input string name, input int inject_at);
        int lat;
        bit seen;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            start = (i + 1 == inject_at);
            if (start) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_product"}, product, exp);
        check({name, "_zhi"}, zhi, exp[2*W-1:W]);
        check({name, "_zlo"}, zlo, exp[W-1:0]);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        #3 clr = 1'b0;
        #1 mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        #2 clr = 1'b1;
        @(posedge clk); #1;

        // Pin the reference model with hand-computed values.
        check("model_4x18", ref_mul(32'd4, 32'h12), 64'h48);
        check("model_m1xm1", ref_mul(32'hFFFFFFFF, 32'hFFFFFFFF), 64'h1);
        check("model_min_sq", ref_mul(32'h80000000, 32'h80000000), 64'h4000000000000000);
        check("model_3xm5", ref_mul(32'd3, 32'hFFFFFFFB), 64'hFFFFFFFFFFFFFFF1);

        // Directed cases with literal expectations
        do_op(32'd4, 32'h12, 64'h0000000000000048, "t1_4x18", 0);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "t2_m1xm1", 0);
        do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF80000001, "t3_maxxm1", 0);
        do_op(32'h80000000, 32'h80000000, 64'h4000000000000000, "t4_min_sq", 0);
        do_op(32'h0000000F, 32'h0, 64'h0, "t4_by_zero", 0);
        do_op(32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, "min_x_max", 0);
        do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, "max_sq", 0);

        // start during RUN is ignored; exactly one done
        d0 = done_cnt;
        do_op(32'd7, 32'd9, 64'd63, "t5_busy_start", 5);
        repeat (25) @(posedge clk);
        #1;
        check("t5_done_count", 64'(done_cnt - d0), 1);
        check("t5_product_held", product, 64'd63);

        // Asynchronous clear in the middle of RUN
        multiplicand = 32'h1234;
        multiplier   = 32'h5678;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (8) @(posedge clk);
        #2 clr = 1'b0;
        #1;
        check("t6_clr_busy", busy, 0);
        check("t6_clr_done", done, 0);
        check("t6_clr_product", product, 0);
        repeat (2) @(posedge clk);
        #3 clr = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("t6_no_done_aborted", 64'(done_cnt - d0), 0);
        do_op(32'd3, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1, "t6_3xm5", 0);

        // Randomized operations with random idle gaps
        for (int k = 0; k < 30; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 5 == 0) ra = {ra[W-1], {(W-1){ra[0]}}};
            if (k % 7 == 0) rb = {rb[W-1], {(W-1){~rb[W-1]}}};
            do_op(ra, rb, ref_mul(ra, rb), "rand", 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // start held high: relaunch on every IDLE cycle, operands changing each cycle
        d0 = done_cnt;
        multiplicand = $urandom;
        multiplier   = $urandom;
        start = 1'b1;
        for (int k = 0; k < 57; k++) begin
            @(posedge clk); #1;
            multiplicand = $urandom;
            multiplier   = $urandom;
        end
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("held_start_dones", 64'(done_cnt - d0), 3);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
